// File: rtl/axil_mitm_rd.sv
// axil_mitm_rd: AXI4-lite read broadcaster that fans one AR out to M_COUNT masters and merges their R beats.
// Optional data cross-check is enabled by defining AXIL_MITM_RD_CMP_EN.
module axil_mitm_rd #(
  parameter int M_COUNT    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SEL   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
  input  logic [2:0]                    s_axil_arprot,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [DATA_WIDTH-1:0]         s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [M_COUNT*ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [M_COUNT*3-1:0]          m_axil_arprot,
  output logic [M_COUNT-1:0]            m_axil_arvalid,
  input  logic [M_COUNT-1:0]            m_axil_arready,
  input  logic [M_COUNT*DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [M_COUNT*2-1:0]          m_axil_rresp,
  input  logic [M_COUNT-1:0]            m_axil_rvalid,
  output logic [M_COUNT-1:0]            m_axil_rready,
  output logic                          mismatch
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0] prot;
  logic [M_COUNT-1:0] r_hs, r_left;
  logic [1:0] resp_max, resp_next;
  assign m_axil_araddr = {M_COUNT{addr}};
  assign m_axil_arprot = {M_COUNT{prot}};
  assign r_hs = m_axil_rvalid & m_axil_rready;
  // m_axil_rready doubles as the per-lane "still waiting" mask
  assign r_left = m_axil_rready & ~r_hs;
  always_comb begin
    resp_max = s_axil_rresp;
    for (int n = 0; n < M_COUNT; n++)
      if (r_hs[n] && m_axil_rresp[2*n +: 2] > resp_max) resp_max = m_axil_rresp[2*n +: 2];
  end
`ifdef AXIL_MITM_RD_CMP_EN
  logic ref_vld, miss, miss_next;
  logic [DATA_WIDTH-1:0] ref_data, cur_ref;
  // reference is the first lane to return; lowest index wins a tie
  always_comb begin
    cur_ref = ref_data;
    for (int n = M_COUNT-1; n >= 0; n--)
      if (!ref_vld && r_hs[n]) cur_ref = m_axil_rdata[n*DATA_WIDTH +: DATA_WIDTH];
    miss_next = miss;
    for (int n = 0; n < M_COUNT; n++)
      if (r_hs[n] && m_axil_rdata[n*DATA_WIDTH +: DATA_WIDTH] != cur_ref) miss_next = 1'b1;
  end
  assign resp_next = (miss_next && resp_max < 2'b10) ? 2'b10 : resp_max;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_vld  <= 1'b0;
      ref_data <= '0;
      miss     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= state == BUSY && r_left == '0 && miss_next;
      ref_vld  <= state == BUSY && (ref_vld || |r_hs);
      miss     <= state == BUSY && miss_next;
      if (state == BUSY && !ref_vld && |r_hs) ref_data <= cur_ref;
    end
  end
`else
  assign resp_next = resp_max;
  assign mismatch = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= 2'b00;
      s_axil_rdata   <= '0;
      m_axil_arvalid <= '0;
      m_axil_rready  <= '0;
      addr           <= '0;
      prot           <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (s_axil_arvalid && s_axil_arready) begin
            addr           <= s_axil_araddr;
            prot           <= s_axil_arprot;
            s_axil_arready <= 1'b0;
            s_axil_rresp   <= 2'b00;
            m_axil_arvalid <= '1;
            m_axil_rready  <= '1;
            state          <= BUSY;
          end else begin
            s_axil_arready <= 1'b1;
          end
        end
        BUSY: begin
          m_axil_arvalid <= m_axil_arvalid & ~m_axil_arready;
          m_axil_rready  <= r_left;
          s_axil_rresp   <= resp_next;
          if (r_hs[DATA_SEL]) s_axil_rdata <= m_axil_rdata[DATA_SEL*DATA_WIDTH +: DATA_WIDTH];
          if (r_left == '0) begin
            s_axil_rvalid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid  <= 1'b0;
            s_axil_arready <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_mitm_rd.sv
// tb_axil_mitm_rd: scoreboard bench for axil_mitm_rd with four master lanes and DATA_SEL=2.
module tb_axil_mitm_rd;
  localparam int MC = 4;
  localparam int SEL = 2;
`ifdef AXIL_MITM_RD_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        m;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] s_araddr = '0;
  logic [2:0] s_arprot = '0;
  logic s_arvalid = 1'b0, s_arready;
  logic [31:0] s_rdata;
  logic [1:0] s_rresp;
  logic s_rvalid, s_rready = 1'b0;
  logic [MC*32-1:0] m_araddr;
  logic [MC*3-1:0] m_arprot;
  logic [MC-1:0] m_arvalid, m_arready = '0;
  logic [MC*32-1:0] m_rdata = '0;
  logic [MC*2-1:0] m_rresp = '0;
  logic [MC-1:0] m_rvalid = '0, m_rready;
  logic mismatch;
  int total = 0, bad = 0;
  int cfg_ar_at[MC], cfg_r_at[MC];
  logic [31:0] cfg_data[MC];
  logic [1:0] cfg_resp[MC];
  exp_t sb[$];
  axil_mitm_rd #(.M_COUNT(MC), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_SEL(SEL)) dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_araddr), .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid),
    .s_axil_arready(s_arready), .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp),
    .s_axil_rvalid(s_rvalid), .s_axil_rready(s_rready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid),
    .m_axil_arready(m_arready), .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready), .mismatch(mismatch)
  );
  always #5 clk = ~clk;
  task automatic cfg_lane(input int n, input int a, input int r, input logic [31:0] d, input logic [1:0] rs);
    cfg_ar_at[n] = a;
    cfg_r_at[n] = r;
    cfg_data[n] = d;
    cfg_resp[n] = rs;
  endtask
  task automatic run_read(input string nm, input logic [31:0] addr, input int hold, output int lat);
    exp_t e;
    logic [MC-1:0] ar_d, r_d;
    logic [31:0] hd;
    logic [1:0] hr;
    bit eq, bad_ar, bad_rr, bad_hold;
    int k, last_r;
    e.d = cfg_data[SEL];
    e.r = 2'b00;
    eq = 1'b1;
    for (int n = 0; n < MC; n++) begin
      if (cfg_resp[n] > e.r) e.r = cfg_resp[n];
      if (cfg_data[n] != cfg_data[0]) eq = 1'b0;
    end
    e.m = CMP && !eq;
    if (e.m && e.r < 2'b10) e.r = 2'b10;
    for (int n = 0; n < MC; n++) begin
      m_rdata[n*32 +: 32] = cfg_data[n];
      m_rresp[n*2 +: 2] = cfg_resp[n];
    end
    @(negedge clk);
    s_araddr = addr;
    s_arprot = 3'b010;
    s_arvalid = 1'b1;
    total++;
    if (s_arready !== 1'b1) begin bad++; $display("FAIL %s arready: got %b want 1", nm, s_arready); end
    sb.push_back(e);
    @(negedge clk);
    s_arvalid = 1'b0;
    total++;
    if (m_araddr !== {MC{addr}} || m_arprot !== {MC{3'b010}}) begin
      bad++; $display("FAIL %s lane addr: got %h/%h want %h", nm, m_araddr, m_arprot, addr);
    end
    k = 1; last_r = 0; ar_d = '0; r_d = '0; bad_ar = 0; bad_rr = 0;
    while (!s_rvalid && k < 200) begin
      if (m_arvalid !== ~ar_d) bad_ar = 1;
      if (m_rready !== ~r_d) bad_rr = 1;
      for (int n = 0; n < MC; n++) begin
        m_arready[n] = !ar_d[n] && k >= cfg_ar_at[n];
        m_rvalid[n] = ar_d[n] && !r_d[n] && k >= cfg_r_at[n];
      end
      for (int n = 0; n < MC; n++) begin
        if (m_arvalid[n] && m_arready[n]) ar_d[n] = 1'b1;
        if (m_rvalid[n] && m_rready[n]) begin r_d[n] = 1'b1; last_r = k; end
      end
      @(negedge clk);
      k++;
    end
    m_arready = '0;
    m_rvalid = '0;
    lat = k;
    total++;
    if (s_rvalid !== 1'b1) begin bad++; $display("FAIL %s timeout: rvalid %b after %0d cycles want 1", nm, s_rvalid, k); end
    total++;
    if (bad_ar || m_arvalid !== '0) begin bad++; $display("FAIL %s m_arvalid: protocol got %b want 0", nm, bad_ar); end
    total++;
    if (bad_rr || m_rready !== '0) begin bad++; $display("FAIL %s m_rready: protocol got %b want 0", nm, bad_rr); end
    total++;
    if (r_d !== '1 || k != last_r + 1) begin bad++; $display("FAIL %s latency: got cycle %0d done %b want %0d", nm, k, r_d, last_r + 1); end
    e = sb.pop_front();
    total++;
    if (s_rdata !== e.d) begin bad++; $display("FAIL %s rdata: got %h want %h", nm, s_rdata, e.d); end
    total++;
    if (s_rresp !== e.r) begin bad++; $display("FAIL %s rresp: got %b want %b", nm, s_rresp, e.r); end
    total++;
    if (mismatch !== e.m) begin bad++; $display("FAIL %s mismatch: got %b want %b", nm, mismatch, e.m); end
    hd = s_rdata; hr = s_rresp; bad_hold = 0;
    repeat (hold) begin
      @(negedge clk);
      if (s_rvalid !== 1'b1 || s_rdata !== hd || s_rresp !== hr || s_arready !== 1'b0 || m_arvalid !== '0 || mismatch !== 1'b0)
        bad_hold = 1;
    end
    if (hold > 0) begin
      total++;
      if (bad_hold) begin bad++; $display("FAIL %s hold: got unstable outputs want stable for %0d cycles", nm, hold); end
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    total++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
      bad++; $display("FAIL %s release: got rvalid %b arready %b want 0/1", nm, s_rvalid, s_arready);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if (s_arready !== 1'b0 || s_rvalid !== 1'b0 || s_rdata !== '0 || s_rresp !== 2'b00 || m_arvalid !== '0 || m_rready !== '0 || mismatch !== 1'b0) begin
      bad++; $display("FAIL reset values: got arready %b rvalid %b rdata %h rresp %b arv %b rr %b mis %b want all 0",
                      s_arready, s_rvalid, s_rdata, s_rresp, m_arvalid, m_rready, mismatch);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_arready !== 1'b1) begin bad++; $display("FAIL reset arready rise: got %b want 1", s_arready); end
  endtask
  task automatic test_basic;
    int lat;
    for (int n = 0; n < MC; n++) cfg_lane(n, 1, 2, 32'hCAFEF00D, 2'b00);
    run_read("basic", 32'h1000, 0, lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL basic min latency: got %0d want 3", lat); end
  endtask
  task automatic test_out_of_order;
    int lat;
    cfg_lane(0, 1, 11, 32'h5A5A0001, 2'b00);
    cfg_lane(1, 4, 10, 32'h5A5A0001, 2'b00);
    cfg_lane(2, 2, 9, 32'h5A5A0001, 2'b00);
    cfg_lane(3, 7, 8, 32'h5A5A0001, 2'b00);
    run_read("ooo", 32'h1004, 0, lat);
    total++;
    if (lat != 12) begin bad++; $display("FAIL ooo latency: got %0d want 12", lat); end
  endtask
  task automatic test_resp;
    int lat;
    for (int n = 0; n < MC; n++) cfg_lane(n, 1, 2 + n, 32'h0000BEEF, 2'b00);
    cfg_resp[2] = 2'b10;
    cfg_resp[3] = 2'b11;
    run_read("resp_dec", 32'h1008, 0, lat);
    cfg_resp[3] = 2'b00;
    run_read("resp_slv", 32'h100C, 0, lat);
    cfg_resp[0] = 2'b01;
    cfg_resp[2] = 2'b00;
    run_read("resp_exok", 32'h1010, 0, lat);
  endtask
  task automatic test_data_sel;
    int lat;
    cfg_lane(0, 1, 2, 32'h11, 2'b00);
    cfg_lane(1, 1, 3, 32'h22, 2'b00);
    cfg_lane(2, 2, 3, 32'h33, 2'b00);
    cfg_lane(3, 1, 4, 32'h44, 2'b00);
    run_read("data_sel", 32'h1014, 0, lat);
  endtask
  task automatic test_back_to_back;
    int lat;
    for (int n = 0; n < MC; n++) cfg_lane(n, 1, 2, 32'h0BADF00D + n*0, 2'b00);
    run_read("hold", 32'h1018, 5, lat);
    for (int n = 0; n < MC; n++) cfg_lane(n, 1 + n, 6, 32'h20002000, 2'b00);
    run_read("second", 32'h2000, 0, lat);
  endtask
  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    s_araddr = 32'h3000;
    s_arvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    m_arready = '1;
    @(negedge clk);
    m_arready = '0;
    m_rvalid = 4'b0011;
    @(negedge clk);
    m_rvalid = '0;
    total++;
    if (m_rready !== 4'b1100) begin bad++; $display("FAIL midrst outstanding: got %b want 1100", m_rready); end
    rst = 1'b1;
    #1;
    total++;
    if (m_arvalid !== '0 || m_rready !== '0 || s_rvalid !== 1'b0 || s_arready !== 1'b0) begin
      bad++; $display("FAIL midrst drop: got arv %b rr %b rvalid %b arready %b want 0", m_arvalid, m_rready, s_rvalid, s_arready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin bad++; $display("FAIL midrst recover: got arready %b rvalid %b want 1/0", s_arready, s_rvalid); end
    for (int n = 0; n < MC; n++) cfg_lane(n, 1, 3, 32'h3000AAAA, 2'b00);
    run_read("after_rst", 32'h3004, 0, lat);
  endtask
  initial begin
    test_reset;
    test_basic;
    test_out_of_order;
    test_resp;
    test_data_sel;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
